// File: rtl/capture_ring_buffer.sv
// Multi-channel waveform capture ring buffer with pre-trigger window.
// Samples stream into a circular RAM while armed; after the trigger the capture is read out oldest-first.
module capture_ring_buffer #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic                         trig,
    input  logic                         arm,
    input  logic                         abort,
    input  logic [ADDR_WIDTH-1:0]        pre_trig,
    input  logic                         rd_en,
    input  logic [CH_W-1:0]              rd_ch,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         rd_last,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_WIDTH-1:0]        trig_addr
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int WORD_W = NUM_CH * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Channel selects outside the stored range yield zero.
    function automatic logic [DATA_WIDTH-1:0] ch_slice(input logic [WORD_W-1:0] word,
                                                       input logic [CH_W-1:0]   ch);
        logic [DATA_WIDTH-1:0] res;
        res = {DATA_WIDTH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            res = (ch == CH_W'(c)) ? word[c*DATA_WIDTH +: DATA_WIDTH] : res;
        end
        return res;
    endfunction

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [WORD_W-1:0]     rd_word_r;

    state_t                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] pre_lat_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] fill_cnt_r;
    logic [ADDR_WIDTH:0]   post_cnt_r;
    logic [ADDR_WIDTH-1:0] trig_addr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_cnt_r;
    logic [CH_W-1:0]       rd_ch_r;
    logic                  rd_seen_r;
    logic                  rd_valid_r;
    logic                  rd_last_r;

    logic                  arm_s;
    logic                  capturing_s;
    logic                  wr_s;
    logic                  trig_hit_s;
    logic                  rd_fire_s;
    logic                  rd_end_s;
    logic [ADDR_WIDTH:0]   span_s;
    logic [ADDR_WIDTH-1:0] fill_next_s;
    logic [ADDR_WIDTH:0]   post_next_s;
    logic [ADDR_WIDTH-1:0] rd_start_s;
    logic                  enter_done_s;

    // Qualified control strobes; abort outranks arm, and both outrank trig and rd_en.
    always_comb begin
        capturing_s  = (state_r == ST_FILL) || (state_r == ST_WAIT_TRIG) || (state_r == ST_POST);
        arm_s        = arm && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        wr_s         = in_valid && capturing_s && !abort;
        trig_hit_s   = wr_s && trig && (state_r == ST_WAIT_TRIG);
        rd_fire_s    = rd_en && (state_r == ST_DONE) && !abort && !arm;
        rd_end_s     = rd_fire_s && (rd_cnt_r == {ADDR_WIDTH{1'b1}});
        span_s       = {1'b1, {ADDR_WIDTH{1'b0}}} - {1'b0, pre_lat_r};
        fill_next_s  = fill_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        post_next_s  = post_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
        // On a direct WAIT_TRIG->DONE jump trig_addr is not yet updated, so use wr_ptr.
        rd_start_s   = ((state_r == ST_WAIT_TRIG) ? wr_ptr_r : trig_addr_r) - pre_lat_r;
        enter_done_s = (state_next_s == ST_DONE) && (state_r != ST_DONE);
    end

    // Next-state decode for the capture/readout sequence.
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (arm_s) begin
                        state_next_s = (pre_trig != {ADDR_WIDTH{1'b0}}) ? ST_FILL : ST_WAIT_TRIG;
                    end else if (rd_end_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_FILL: begin
                    if (wr_s && (fill_next_s == pre_lat_r)) begin
                        state_next_s = ST_WAIT_TRIG;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_hit_s) begin
                        state_next_s = (span_s == {{ADDR_WIDTH{1'b0}}, 1'b1}) ? ST_DONE : ST_POST;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_POST: begin
                    if (wr_s && (post_next_s == span_s)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pre_lat_r   <= {ADDR_WIDTH{1'b0}};
            wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
            fill_cnt_r  <= {ADDR_WIDTH{1'b0}};
            post_cnt_r  <= {(ADDR_WIDTH+1){1'b0}};
            trig_addr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
            rd_cnt_r    <= {ADDR_WIDTH{1'b0}};
            rd_ch_r     <= {CH_W{1'b0}};
            rd_seen_r   <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (arm_s) begin
                pre_lat_r  <= pre_trig;
                wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
                fill_cnt_r <= {ADDR_WIDTH{1'b0}};
            end else if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (state_r == ST_FILL) begin
                    fill_cnt_r <= fill_next_s;
                end
                if (trig_hit_s) begin
                    trig_addr_r <= wr_ptr_r;
                    post_cnt_r  <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                end else if (state_r == ST_POST) begin
                    post_cnt_r <= post_next_s;
                end
            end
            if (enter_done_s) begin
                rd_ptr_r <= rd_start_s;
                rd_cnt_r <= {ADDR_WIDTH{1'b0}};
            end else if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                rd_cnt_r <= rd_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (rd_fire_s) begin
                rd_ch_r   <= rd_ch;
                rd_seen_r <= 1'b1;
            end
            rd_valid_r <= rd_fire_s;
            rd_last_r  <= rd_end_s;
        end
    end

    // Simple dual-port RAM: no reset so it maps onto block RAM with a registered read.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem[wr_ptr_r] <= in_data;
        end
        if (rd_fire_s) begin
            rd_word_r <= mem[rd_ptr_r];
        end
    end

    // rd_word_r and rd_ch_r only move on a read, so rd_data holds between strobes.
    assign rd_data   = rd_seen_r ? ch_slice(rd_word_r, rd_ch_r) : {DATA_WIDTH{1'b0}};
    assign rd_valid  = rd_valid_r;
    assign rd_last   = rd_last_r;
    assign busy      = (state_r == ST_FILL) || (state_r == ST_WAIT_TRIG) || (state_r == ST_POST);
    assign done      = (state_r == ST_DONE);
    assign trig_addr = trig_addr_r;

endmodule

// File: tb/tb_capture_ring_buffer.sv
// Directed bench for capture_ring_buffer at DEPTH=16, two channels (ch0 = n, ch1 = n+100).
module tb_capture_ring_buffer;

    localparam int DW = 11;
    localparam int AW = 4;
    localparam int NCH = 2;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [NCH*DW-1:0] in_data;
    logic              trig;
    logic              arm;
    logic              abort;
    logic [AW-1:0]     pre_trig;
    logic              rd_en;
    logic [CW-1:0]     rd_ch;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              busy;
    logic              done;
    logic [AW-1:0]     trig_addr;

    int n_checks = 0;
    int n_errors = 0;
    int last_n;

    capture_ring_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .CH_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .trig(trig), .arm(arm), .abort(abort), .pre_trig(pre_trig),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_last(rd_last), .busy(busy), .done(done), .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Arms a capture and streams n = 0,1,2,... until done (or the abort sample).
    task automatic run_capture(input int pre, input int trig_a, input int trig_b,
                               input bit gapped, input int abort_n, output int last);
        int n;
        bit stop;
        n = 0;
        stop = 1'b0;
        last = -1;
        @(negedge clk);
        arm = 1'b1;
        pre_trig = AW'(pre);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            arm = 1'b0;
            abort = 1'b0;
            if (cyc == 0) check("busy_armed", 32'(busy), 32'd1);
            if (done || stop) break;
            if (gapped && (cyc % 2 == 1)) begin
                in_valid = 1'b0;
                trig = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_data = {DW'(n + 100), DW'(n)};
                trig = (n == trig_a) || (n == trig_b);
                if (n == abort_n) begin
                    abort = 1'b1;
                    stop = 1'b1;
                end
                last = n;
                n++;
            end
        end
        in_valid = 1'b0;
        trig = 1'b0;
        abort = 1'b0;
        if (abort_n >= 0) check("busy_after_abort", 32'(busy), 32'd0);
        else check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic do_readout(input int ch, input int first, input int count);
        int exp;
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            rd_en = 1'b1;
            rd_ch = CW'(ch);
            @(negedge clk);
            rd_en = 1'b0;
            exp = (ch == 0) ? first + i : (ch == 1) ? first + i + 100 : 0;
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data", 32'(rd_data), exp);
            check("rd_last", 32'(rd_last), 32'(i == 15));
        end
        @(negedge clk);
        check("rd_valid_pulse", 32'(rd_valid), 32'd0);
        if (count == 16) check("done_after_read", 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        trig = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        pre_trig = '0;
        rd_en = 1'b0;
        rd_ch = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
        rst_n = 1'b1;

        // Basic pre-trigger capture, both channels.
        run_capture(4, 10, -1, 1'b0, -1, last_n);
        check("s1_last_n", last_n, 21);
        check("s1_trig_addr", 32'(trig_addr), 32'd10);
        do_readout(0, 6, 16);
        run_capture(4, 10, -1, 1'b0, -1, last_n);
        check("s1b_last_n", last_n, 21);
        do_readout(1, 6, 16);

        // No pre-trigger window, and maximal window that skips POST.
        run_capture(0, 3, -1, 1'b0, -1, last_n);
        check("s2a_last_n", last_n, 18);
        check("s2a_trig_addr", 32'(trig_addr), 32'd3);
        do_readout(0, 3, 16);
        run_capture(15, 20, -1, 1'b0, -1, last_n);
        check("s2b_last_n", last_n, 20);
        check("s2b_trig_addr", 32'(trig_addr), 32'd4);
        do_readout(0, 5, 16);

        // Trigger during FILL is ignored; write pointer wraps.
        run_capture(8, 2, 12, 1'b0, -1, last_n);
        check("s3_last_n", last_n, 19);
        check("s3_trig_addr", 32'(trig_addr), 32'd12);
        do_readout(0, 4, 16);

        // Abort during POST, then abort together with arm.
        run_capture(4, 10, -1, 1'b0, 14, last_n);
        repeat (3) begin
            @(negedge clk);
            check("s4_no_done", 32'(done), 32'd0);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check("s4_no_rd_valid", 32'(rd_valid), 32'd0);
        check("s4_trig_addr_hold", 32'(trig_addr), 32'd10);
        abort = 1'b1;
        arm = 1'b1;
        pre_trig = AW'(4);
        @(negedge clk);
        abort = 1'b0;
        arm = 1'b0;
        check("s4_abort_arm_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("s4_abort_arm_idle", 32'(busy | done), 32'd0);

        // Reset in the middle of a readout.
        run_capture(4, 10, -1, 1'b0, -1, last_n);
        do_readout(0, 6, 5);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("s5_pre_rst_valid", 32'(rd_valid), 32'd1);
        check("s5_pre_rst_data", 32'(rd_data), 32'd11);
        rst_n = 1'b0;
        #1;
        check("s5_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("s5_rst_rd_data", 32'(rd_data), 32'd0);
        check("s5_rst_done", 32'(done), 32'd0);
        check("s5_rst_trig_addr", 32'(trig_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check("s5_rd_ignored", 32'(rd_valid), 32'd0);

        // Out-of-range channel, then gapped input.
        run_capture(4, 10, -1, 1'b0, -1, last_n);
        do_readout(3, 6, 16);
        run_capture(4, 10, -1, 1'b1, -1, last_n);
        check("s6_last_n", last_n, 21);
        check("s6_trig_addr", 32'(trig_addr), 32'd10);
        do_readout(0, 6, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/capture_ring_buffer.md
Name: capture_ring_buffer

Overview:
Parametrised, single-clock, multi-channel waveform capture buffer with a pre-trigger window, built on an inferred simple dual-port block RAM.
- Samples are written into a circular buffer of DEPTH = 2^ADDR_WIDTH words while armed.
- On a trigger it fills the remaining post-trigger samples, then stops.
- The capture is then read out oldest-first, one selected channel at a time.
- It sits between the ADC sample front end and the display/measurement readout logic. It supersedes the fixed 8192x11 RAM instances with a generalised width, depth and channel count plus capture control.

Parameters:
- DATA_WIDTH, 11: bits per channel sample.
- ADDR_WIDTH, 13: buffer depth is 2^ADDR_WIDTH samples per channel.
- NUM_CH, 2: channels stored side by side in one RAM word of NUM_CH*DATA_WIDTH bits.
- CH_W, 1: width of the channel select; must satisfy 2^CH_W >= NUM_CH.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample strobe.
- in_data  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- trig  in  1  trigger qualifier; only meaningful together with in_valid.
- arm  in  1  one-cycle pulse that starts a capture.
- abort  in  1  one-cycle pulse that cancels any capture or readout.
- pre_trig  in  ADDR_WIDTH  pre-trigger sample count, latched on arm.
- rd_en  in  1  readout advance strobe.
- rd_ch  in  CH_W  channel select, sampled with rd_en.
- rd_data  out  DATA_WIDTH  readout sample.
- rd_valid  out  1  rd_data valid strobe.
- rd_last  out  1  marks the final readout sample.
- busy  out  1  high in FILL, WAIT_TRIG and POST.
- done  out  1  high in DONE.
- trig_addr  out  ADDR_WIDTH  RAM address at which the trigger sample was written.

Behaviour:
Reset:
- rst_n low: state IDLE.
- All outputs 0; wr_ptr, rd_ptr and all counters 0.
- RAM contents are undefined and are not cleared.

States: IDLE, FILL, WAIT_TRIG, POST, DONE.

IDLE:
- in_valid is ignored (no writes).
- arm -> latch pre_trig into pre_lat, clear wr_ptr and fill_cnt.
- Next state is FILL if pre_lat != 0, otherwise WAIT_TRIG.

Clamping:
- pre_trig is a full ADDR_WIDTH value, so it can never exceed DEPTH-1. No clamp is required.

Writing (FILL, WAIT_TRIG, POST):
- Each in_valid writes in_data at wr_ptr, then wr_ptr increments modulo DEPTH (wraps 2^ADDR_WIDTH-1 -> 0).

FILL:
- Each write increments fill_cnt.
- When the write makes fill_cnt equal pre_lat, the next state is WAIT_TRIG.
- trig is ignored in FILL.

WAIT_TRIG:
- A sample with in_valid=1 and trig=1 is the trigger sample. It is written, trig_addr := wr_ptr, and post_cnt := 1.
- If DEPTH - pre_lat == 1, go directly to DONE; otherwise go to POST.
- trig with in_valid=0 is ignored.

POST:
- Each write increments post_cnt.
- The write that makes post_cnt equal DEPTH - pre_lat is the last write; the next state is DONE.
- trig is ignored in POST.

DONE:
- rd_ptr is initialised to trig_addr - pre_lat (mod DEPTH) on entry.
- rd_en reads RAM[rd_ptr] and increments rd_ptr.
- rd_data is the rd_ch slice, with read latency exactly 1 cycle: rd_valid pulses on the cycle after rd_en.
- rd_ch >= NUM_CH returns 0 with rd_valid still asserted.
- The DEPTH-th read asserts rd_last together with its rd_valid; the state then returns to IDLE.
- rd_en outside DONE, or after the last read, is ignored.

Readout order:
- Index pre_lat of the readout holds the trigger sample.
- The total written is at least DEPTH, so every read location holds valid data.

Priority and simultaneous events:
- abort beats arm; both beat trig and rd_en.
- abort in any state -> IDLE next cycle: busy=done=0, rd_valid=0, and no pending read is delivered.
- arm in DONE restarts a capture (same handling as arm in IDLE). Any unread data is discarded.
- arm in FILL, WAIT_TRIG or POST is ignored.

Register behaviour:
- trig_addr holds its value until the next trigger or reset.
- rd_data holds its last value when rd_valid=0.

Test Plan (ADDR_WIDTH=4, DEPTH=16, NUM_CH=2, ch0 = sample index n, ch1 = n+100, in_valid continuous from arm):
1. pre_trig=4, trig at n=10 -> done after the write of n=21.
   - trig_addr=10.
   - 16 reads on ch0 return 6..21; the 5th read returns 10; rd_last on 21; each rd_valid 1 cycle after its rd_en.
   - Repeat with rd_ch=1: returns 106..121.
2. pre_trig=0, trig at n=3 -> no FILL; ch0 readout 3..18.
   - pre_trig=15, trig at n=20 -> POST skipped; readout 5..20.
3. pre_trig=8, trig at n=2 (ignored during FILL) and at n=12 -> trigger at 12; readout 4..19.
   - wr_ptr wrap verified: trig_addr=12, and sample 16 stored at address 0.
4. abort during POST (n=14) -> busy=0 next cycle, done never asserts, rd_en produces no rd_valid.
   - abort and arm in the same cycle -> stays IDLE.
5. rst_n low mid-readout (after 5 reads) -> immediately rd_valid=0, rd_data=0, done=0, trig_addr=0.
   - After release, rd_en is ignored until a new capture completes.
6. rd_ch=3 -> rd_data=0 with rd_valid=1.
   - in_valid gapped (every other cycle) with pre_trig=4, trig at n=10 -> same result as scenario 1.
